// File: rtl/imem_loader.sv
// Instruction memory loader: clears the memory, then writes switch words committed by
// key strobes to consecutive addresses while holding the processor in reset.
module imem_loader #(
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              LoadEn,
  input  logic              Strobe,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              Finish,
  output logic              MemWr,
  output logic [ADDR_W-1:0] MemWrAddr,
  output logic [DATA_W-1:0] MemWrData,
  output logic              ProcHold,
  output logic              Busy,
  output logic              Done,
  output logic              Full,
  output logic [ADDR_W:0]   WordCount,
  output logic [DATA_W-1:0] Checksum
);

  typedef enum logic [2:0] {StIdle, StClear, StLoad, StWrite, StDone} state_e;

  state_e              state_q, state_d;
  logic                load_en_q;
  logic [ADDR_W-1:0]   clr_q, clr_d;
  logic                fin_q, fin_d;
  logic                full_q, full_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  // Doubles as the captured word: it holds the strobed data through the WRITE cycle.
  logic [DATA_W-1:0]   data_q, data_d;

  // Next-state logic; write-port registers are computed from the next state so they
  // line up with the state they belong to.
  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    fin_d   = fin_q;
    full_d  = full_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (LoadEn && !load_en_q) begin
          state_d = StClear;
          clr_d   = '0;
          cnt_d   = '0;
          sum_d   = '0;
          full_d  = 1'b0;
          fin_d   = 1'b0;
          wr_d    = 1'b1;
          addr_d  = '0;
          data_d  = '0;
        end
      end
      StClear: begin
        if (clr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = StLoad;
        end else begin
          clr_d  = clr_q + ADDR_W'(1);
          wr_d   = 1'b1;
          addr_d = clr_q + ADDR_W'(1);
        end
      end
      StLoad: begin
        if (Strobe) begin
          state_d = StWrite;
          fin_d   = Finish;
          wr_d    = 1'b1;
          addr_d  = cnt_q[ADDR_W-1:0];
          data_d  = DataIn;
        end else if (Finish) begin
          state_d = StDone;
        end
      end
      StWrite: begin
        cnt_d = cnt_q + (ADDR_W + 1)'(1);
        sum_d = sum_q + data_q;
        if (cnt_d == (ADDR_W + 1)'(DEPTH)) begin
          full_d  = 1'b1;
          state_d = StDone;
        end else if (fin_q) begin
          state_d = StDone;
        end else begin
          state_d = StLoad;
        end
      end
      StDone: begin
        if (!LoadEn) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counters and registered write port; reset aborts any write at once.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= StIdle;
      load_en_q <= 1'b0;
      clr_q     <= '0;
      fin_q     <= 1'b0;
      full_q    <= 1'b0;
      cnt_q     <= '0;
      sum_q     <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      load_en_q <= LoadEn;
      clr_q     <= clr_d;
      fin_q     <= fin_d;
      full_q    <= full_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    Busy      = (state_q == StClear) || (state_q == StLoad) || (state_q == StWrite);
    ProcHold  = Busy;
    Done      = (state_q == StDone);
    Full      = full_q;
    WordCount = cnt_q;
    Checksum  = sum_q;
    MemWr     = wr_q;
    MemWrAddr = addr_q;
    MemWrData = data_q;
  end

endmodule
